cache_flush_walker: RTL and testbench
=====================================

Name: cache_flush_walker

Overview:
- Sequential client of the cache line store's read/write ports: sweeps every line index, writes back MODIFIED lines to memory, then invalidates or cleans each line.
- Sits beside the cache controller. Borrows the line-store ports through a lock handshake.
- Used for cache flush/clean operations, e.g. before DMA or a coherence domain change.

Parameters:
- INDEX_BITS, 9, line index width; DEPTH = 1 << INDEX_BITS.
- TAG_BITS, 17, tag width; wb_addr = {tag, index}.
- LINE_BITS, 128, line data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush_start  in  1  one-cycle start request; sampled only in IDLE
- flush_inval  in  1  sampled with flush_start; 1 = end state INVALID, 0 = clean (MODIFIED->EXCLUSIVE, others untouched)
- flush_busy  out  1  high from accepted start until the DONE cycle inclusive
- flush_done  out  1  one-cycle pulse at end of sweep
- lock_req  out  1  request exclusive use of line-store ports
- lock_gnt  in  1  controller has yielded ports
- index_rd  out  INDEX_BITS  line-store read index
- index_wr  out  INDEX_BITS  line-store write index
- write_data  out  1  tied 0; walker never writes tag/data
- write_state  out  1  state write strobe
- state_wr  out  2  state to write (line_state encoding)
- tag_rd  in  TAG_BITS  read tag, registered one cycle after index_rd
- data_rd  in  LINE_BITS  read data, same latency
- state_rd  in  2  read state, same latency
- wb_valid  out  1  write-back request valid
- wb_ready  in  1  memory accepts write-back
- wb_addr  out  TAG_BITS+INDEX_BITS  line address of write-back
- wb_data  out  LINE_BITS  line data of write-back

Behaviour:
- Reset (async, rst_n low): state IDLE; idx=0. All outputs 0: flush_busy, flush_done, lock_req, write_state, wb_valid, index_rd/index_wr, state_wr, wb_addr, wb_data.
- Line-store timing: the store returns tag/data/state one cycle after index_rd is driven. A state write commits at the clock edge where write_state=1.
- FSM: IDLE, LOCK, READ, CHECK, WB, UPDATE, DONE.
- IDLE:
  - flush_start=1: latch flush_inval; idx<=0; go to LOCK; flush_busy<=1.
  - Otherwise stay in IDLE.
- LOCK: lock_req=1. When lock_gnt=1, go to READ. lock_req stays 1 through DONE inclusive.
- READ: index_rd=idx; go to CHECK.
- CHECK: capture tag_rd/state_rd/data_rd into holding registers. Then:
  - state MODIFIED -> WB.
  - state INVALID -> advance.
  - Otherwise: inval=1 -> UPDATE; inval=0 -> advance (clean lines untouched).
- WB:
  - wb_valid=1, wb_addr={held tag, idx}, wb_data=held data.
  - All three held stable until the cycle with wb_ready=1; then go to UPDATE.
  - wb_valid deasserts the cycle after the handshake.
- UPDATE:
  - write_state=1 for exactly one cycle; index_wr=idx.
  - state_wr = INVALID if inval, else EXCLUSIVE.
  - Then advance.
- advance: if idx==DEPTH-1 go to DONE; else idx<=idx+1 and go to READ. No wrap past DEPTH-1.
- DONE: flush_done=1 for one cycle; lock_req and flush_busy fall the next cycle; return to IDLE.
- Per-line cycle costs:
  - INVALID line: 2 cycles.
  - Clean line with inval: 3 cycles.
  - MODIFIED line: 4 cycles plus wb_ready stall cycles.
- flush_start while busy: ignored, not queued.
- lock_gnt dropping mid-sweep: protocol violation; covered by assertion only, no recovery.
- Reset mid-sweep: abort immediately. No write_state or wb_valid is issued after reset asserts. A write-back in flight is dropped; memory side must tolerate this.
- Read/write index collision: the walker never reads and writes in the same cycle, so no bypass is needed.

Test Plan:
- INDEX_BITS=2, all lines INVALID; start, inval=1, lock_gnt=1 immediately -> no write_state, no wb_valid; flush_done pulses once; LOCK-to-DONE = 1+4*2 cycles.
- Lines {M tag=0x5 data=D0, S, E, I}; inval=1; wb_ready=1 -> one write-back wb_addr={0x5,2'd0}, data D0; write_state at idx 0,1,2 only, each with state_wr=INVALID.
- Same contents, inval=0 -> one write-back; single write_state at idx 0 with state_wr=EXCLUSIVE; lines 1..3 unchanged.
- MODIFIED line, wb_ready held 0 for 5 cycles -> wb_valid/wb_addr/wb_data stable all 6 cycles; UPDATE only after the handshake.
- lock_gnt delayed 3 cycles -> lock_req high and no index activity until grant; flush_start pulsed mid-sweep -> no restart, single flush_done.
- rst_n asserted during WB -> wb_valid, lock_req, flush_busy low immediately. After release, a new flush_start sweeps from idx 0.

Source files
------------

// File: rtl/cache_flush_walker.sv
// Walks every cache line index, writes back MODIFIED lines and then invalidates or
// cleans each line while holding the line-store ports via a lock handshake.
module cache_flush_walker #(
    parameter int INDEX_BITS = 9,
    parameter int TAG_BITS   = 17,
    parameter int LINE_BITS  = 128
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush_start,
    input  logic                          flush_inval,
    output logic                          flush_busy,
    output logic                          flush_done,
    output logic                          lock_req,
    input  logic                          lock_gnt,
    output logic [INDEX_BITS-1:0]         index_rd,
    output logic [INDEX_BITS-1:0]         index_wr,
    output logic                          write_data,
    output logic                          write_state,
    output logic [1:0]                    state_wr,
    input  logic [TAG_BITS-1:0]           tag_rd,
    input  logic [LINE_BITS-1:0]          data_rd,
    input  logic [1:0]                    state_rd,
    output logic                          wb_valid,
    input  logic                          wb_ready,
    output logic [TAG_BITS+INDEX_BITS-1:0] wb_addr,
    output logic [LINE_BITS-1:0]          wb_data
);

    // line_state encoding shared with the line store
    localparam logic [1:0] LS_INVALID   = 2'd0;
    localparam logic [1:0] LS_EXCLUSIVE = 2'd2;
    localparam logic [1:0] LS_MODIFIED  = 2'd3;

    localparam logic [INDEX_BITS-1:0] IDX_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOCK, S_READ, S_CHECK, S_WB, S_UPDATE, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [INDEX_BITS-1:0] idx_q;
    logic                  inval_q;
    logic [TAG_BITS-1:0]   tag_h;
    logic [LINE_BITS-1:0]  data_h;
    logic                  advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            inval_q <= 1'b0;
            tag_h   <= '0;
            data_h  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && flush_start) begin
                inval_q <= flush_inval;
                idx_q   <= '0;
            end
            if (state_q == S_CHECK) begin
                tag_h  <= tag_rd;
                data_h <= data_rd;
            end
            if (advance && idx_q != IDX_LAST) begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        case (state_q)
            S_IDLE:   if (flush_start) state_d = S_LOCK;
            S_LOCK:   if (lock_gnt) state_d = S_READ;
            S_READ:   state_d = S_CHECK;
            S_CHECK: begin
                // clean sweeps leave non-MODIFIED lines alone
                if (state_rd == LS_MODIFIED) begin
                    state_d = S_WB;
                end else if (state_rd == LS_INVALID || !inval_q) begin
                    advance = 1'b1;
                end else begin
                    state_d = S_UPDATE;
                end
            end
            S_WB:     if (wb_ready) state_d = S_UPDATE;
            S_UPDATE: advance = 1'b1;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (advance) begin
            state_d = (idx_q == IDX_LAST) ? S_DONE : S_READ;
        end
    end

    always_comb begin
        flush_busy  = 1'b0;
        flush_done  = 1'b0;
        lock_req    = 1'b0;
        index_rd    = '0;
        index_wr    = '0;
        write_data  = 1'b0;
        write_state = 1'b0;
        state_wr    = LS_INVALID;
        wb_valid    = 1'b0;
        wb_addr     = '0;
        wb_data     = '0;
        if (state_q != S_IDLE) begin
            flush_busy = 1'b1;
            lock_req   = 1'b1;
        end
        case (state_q)
            S_READ: index_rd = idx_q;
            S_WB: begin
                wb_valid = 1'b1;
                wb_addr  = {tag_h, idx_q};
                wb_data  = data_h;
            end
            S_UPDATE: begin
                write_state = 1'b1;
                index_wr    = idx_q;
                state_wr    = inval_q ? LS_INVALID : LS_EXCLUSIVE;
            end
            S_DONE: flush_done = 1'b1;
            default: ;
        endcase
    end

    // The controller must not take the ports back while the walker is using them.
    a_lock_held: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q inside {S_READ, S_CHECK, S_WB, S_UPDATE}) |-> lock_gnt);

endmodule

// File: tb/tb_cache_flush_walker.sv
// Directed bench for cache_flush_walker on a 4-line store model.
module tb_cache_flush_walker;

    localparam int IB = 2;
    localparam int TB = 17;
    localparam int LB = 128;

    localparam logic [1:0] LS_I = 2'd0;
    localparam logic [1:0] LS_S = 2'd1;
    localparam logic [1:0] LS_E = 2'd2;
    localparam logic [1:0] LS_M = 2'd3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush_start = 1'b0;
    logic          flush_inval = 1'b0;
    logic          flush_busy, flush_done, lock_req;
    logic          lock_gnt = 1'b1;
    logic [IB-1:0] index_rd, index_wr;
    logic          write_data, write_state;
    logic [1:0]    state_wr;
    logic [TB-1:0] tag_rd = '0;
    logic [LB-1:0] data_rd = '0;
    logic [1:0]    state_rd = '0;
    logic          wb_valid;
    logic          wb_ready = 1'b1;
    logic [TB+IB-1:0] wb_addr;
    logic [LB-1:0] wb_data;

    cache_flush_walker #(.INDEX_BITS(IB), .TAG_BITS(TB), .LINE_BITS(LB)) dut (
        .clk(clk), .rst_n(rst_n), .flush_start(flush_start), .flush_inval(flush_inval),
        .flush_busy(flush_busy), .flush_done(flush_done), .lock_req(lock_req),
        .lock_gnt(lock_gnt), .index_rd(index_rd), .index_wr(index_wr),
        .write_data(write_data), .write_state(write_state), .state_wr(state_wr),
        .tag_rd(tag_rd), .data_rd(data_rd), .state_rd(state_rd), .wb_valid(wb_valid),
        .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    logic [TB-1:0] tag_mem [4];
    logic [LB-1:0] data_mem [4];
    logic [1:0]    st_mem [4];

    always @(posedge clk) begin
        tag_rd   <= tag_mem[index_rd];
        data_rd  <= data_mem[index_rd];
        state_rd <= st_mem[index_rd];
    end

    logic [IB-1:0]    ws_idx [$];
    logic [1:0]       ws_val [$];
    logic [TB+IB-1:0] wba_q [$];
    logic [LB-1:0]    wbd_q [$];
    int               done_cnt = 0;

    always @(posedge clk) begin
        if (write_state) begin
            ws_idx.push_back(index_wr);
            ws_val.push_back(state_wr);
        end
        if (wb_valid && wb_ready) begin
            wba_q.push_back(wb_addr);
            wbd_q.push_back(wb_data);
        end
        if (flush_done) done_cnt++;
    end

    int checks = 0;
    int passed = 0;

    logic [LB-1:0] d0 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    logic [LB-1:0] d1 = 128'hdead_beef_cafe_f00d_1111_2222_3333_4444;
    logic [LB-1:0] d2 = 128'h5555_aaaa_5555_aaaa_0f0f_f0f0_0f0f_f0f0;

    task automatic set_line(input int i, input logic [TB-1:0] t, input logic [LB-1:0] d,
                            input logic [1:0] s);
        tag_mem[i]  = t;
        data_mem[i] = d;
        st_mem[i]   = s;
    endtask

    task automatic start_flush(input logic inv);
        @(posedge clk); #1;
        flush_start = 1'b1;
        flush_inval = inv;
        @(posedge clk); #1;
        flush_start = 1'b0;
        flush_inval = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc, output bit found);
        cyc = 0;
        found = 1'b0;
        while (cyc < budget && !found) begin
            @(negedge clk);
            cyc++;
            if (flush_done) found = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({flush_busy, flush_done, lock_req, write_state, wb_valid, write_data} !== 6'b0)
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {flush_busy, flush_done, lock_req, write_state, wb_valid, write_data});
        else passed++;
        checks++;
        if ({index_rd, index_wr, state_wr, wb_addr} !== '0 || wb_data !== '0)
            $display("FAIL reset_data: got idx %0h/%0h st %0h addr %0h data %0h expected zeros",
                     index_rd, index_wr, state_wr, wb_addr, wb_data);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_all_invalid;
        int cyc; bit found; int ws0, wb0, dn0;
        for (int i = 0; i < 4; i++) set_line(i, 17'h0, '0, LS_I);
        ws0 = ws_idx.size(); wb0 = wba_q.size(); dn0 = done_cnt;
        lock_gnt = 1'b1;
        start_flush(1'b1);
        wait_done(50, cyc, found);
        checks++;
        if (!found || cyc - 1 != 9)
            $display("FAIL inv_latency: got found=%0d lock_to_done=%0d expected 1/9", found, cyc - 1);
        else passed++;
        checks++;
        if ({flush_busy, lock_req} !== 2'b11)
            $display("FAIL inv_busy_at_done: got %b expected 11", {flush_busy, lock_req});
        else passed++;
        @(negedge clk);
        checks++;
        if ({flush_busy, lock_req, flush_done} !== 3'b000)
            $display("FAIL inv_after_done: got %b expected 000", {flush_busy, lock_req, flush_done});
        else passed++;
        checks++;
        if (ws_idx.size() - ws0 != 0 || wba_q.size() - wb0 != 0 || done_cnt - dn0 != 1)
            $display("FAIL inv_activity: got ws=%0d wb=%0d done=%0d expected 0/0/1",
                     ws_idx.size() - ws0, wba_q.size() - wb0, done_cnt - dn0);
        else passed++;
    endtask

    task automatic test_mixed(input logic inv);
        int cyc; bit found; int ws0, wb0, n_ws, exp_cyc;
        set_line(0, 17'h5, d0, LS_M);
        set_line(1, 17'h11, d1, LS_S);
        set_line(2, 17'h22, d2, LS_E);
        set_line(3, 17'h33, '0, LS_I);
        ws0 = ws_idx.size(); wb0 = wba_q.size();
        wb_ready = 1'b1;
        exp_cyc = inv ? 14 : 12;
        n_ws = inv ? 3 : 1;
        start_flush(inv);
        wait_done(60, cyc, found);
        checks++;
        if (!found || cyc != exp_cyc)
            $display("FAIL mixed_latency inv=%0d: got found=%0d cyc=%0d expected 1/%0d",
                     inv, found, cyc, exp_cyc);
        else passed++;
        checks++;
        if (wba_q.size() - wb0 != 1)
            $display("FAIL mixed_wb_count inv=%0d: got %0d expected 1", inv, wba_q.size() - wb0);
        else begin
            if (wba_q[wb0] !== {17'h5, 2'd0} || wbd_q[wb0] !== d0)
                $display("FAIL mixed_wb_line inv=%0d: got addr %0h data %0h expected %0h/%0h",
                         inv, wba_q[wb0], wbd_q[wb0], {17'h5, 2'd0}, d0);
            else passed++;
        end
        checks++;
        if (ws_idx.size() - ws0 != n_ws)
            $display("FAIL mixed_ws_count inv=%0d: got %0d expected %0d",
                     inv, ws_idx.size() - ws0, n_ws);
        else passed++;
        for (int k = 0; k < n_ws && ws0 + k < ws_idx.size(); k++) begin
            checks++;
            if (ws_idx[ws0 + k] !== IB'(k) || ws_val[ws0 + k] !== (inv ? LS_I : LS_E))
                $display("FAIL mixed_ws_%0d inv=%0d: got idx %0d st %0d expected %0d/%0d",
                         k, inv, ws_idx[ws0 + k], ws_val[ws0 + k], k, inv ? LS_I : LS_E);
            else passed++;
        end
        @(negedge clk);
    endtask

    task automatic test_wb_stall;
        int cyc; bit found; int ws0, wb0, k; bit stable;
        logic [TB+IB-1:0] a0; logic [LB-1:0] dd;
        set_line(0, 17'h1abcd, d1, LS_M);
        for (int i = 1; i < 4; i++) set_line(i, 17'h0, '0, LS_I);
        ws0 = ws_idx.size(); wb0 = wba_q.size();
        wb_ready = 1'b0;
        start_flush(1'b1);
        found = 1'b0; k = 0;
        while (k < 20 && !found) begin
            @(negedge clk); k++;
            if (wb_valid) found = 1'b1;
        end
        checks++;
        if (!found || wb_addr !== {17'h1abcd, 2'd0} || wb_data !== d1)
            $display("FAIL stall_first: got valid=%0d addr %0h data %0h expected 1/%0h/%0h",
                     found, wb_addr, wb_data, {17'h1abcd, 2'd0}, d1);
        else passed++;
        a0 = wb_addr; dd = wb_data; stable = 1'b1;
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            if (!wb_valid || wb_addr !== a0 || wb_data !== dd || write_state) stable = 1'b0;
        end
        checks++;
        if (!stable || ws_idx.size() != ws0)
            $display("FAIL stall_stable: got stable=%0d ws=%0d expected 1/0", stable, ws_idx.size() - ws0);
        else passed++;
        wb_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({wb_valid, write_state} !== 2'b01 || index_wr !== 2'd0 || state_wr !== LS_I)
            $display("FAIL stall_update: got valid/ws %b idx %0d st %0d expected 01/0/0",
                     {wb_valid, write_state}, index_wr, state_wr);
        else passed++;
        wb_ready = 1'b0;
        wait_done(40, cyc, found);
        checks++;
        if (!found || wba_q.size() - wb0 != 1 || ws_idx.size() - ws0 != 1)
            $display("FAIL stall_totals: got done=%0d wb=%0d ws=%0d expected 1/1/1",
                     found, wba_q.size() - wb0, ws_idx.size() - ws0);
        else passed++;
        wb_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_gnt_delay;
        int cyc; bit found; int dn0; bit ok;
        for (int i = 0; i < 4; i++) set_line(i, 17'h0, '0, LS_I);
        dn0 = done_cnt;
        lock_gnt = 1'b0;
        start_flush(1'b0);
        ok = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (!lock_req || !flush_busy || write_state || wb_valid || flush_done) ok = 1'b0;
        end
        checks++;
        if (!ok) $display("FAIL gnt_wait: got ok=%0d expected 1", ok);
        else passed++;
        lock_gnt = 1'b1;
        cyc = 0; found = 1'b0;
        while (cyc < 40 && !found) begin
            @(negedge clk); cyc++;
            flush_start = (cyc == 2);
            if (flush_done) found = 1'b1;
        end
        flush_start = 1'b0;
        checks++;
        if (!found || cyc != 9)
            $display("FAIL gnt_latency: got found=%0d cyc=%0d expected 1/9", found, cyc);
        else passed++;
        ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (lock_req || flush_busy) ok = 1'b0;
        end
        checks++;
        if (!ok || done_cnt - dn0 != 1)
            $display("FAIL restart_ignored: got idle_ok=%0d done=%0d expected 1/1", ok, done_cnt - dn0);
        else passed++;
    endtask

    task automatic test_reset_mid_wb;
        int cyc; bit found; int ws0, wb0, k;
        set_line(0, 17'h0, '0, LS_I);
        set_line(1, 17'h0, '0, LS_I);
        set_line(2, 17'h7, d2, LS_M);
        set_line(3, 17'h0, '0, LS_I);
        ws0 = ws_idx.size(); wb0 = wba_q.size();
        wb_ready = 1'b0;
        start_flush(1'b1);
        found = 1'b0; k = 0;
        while (k < 30 && !found) begin
            @(negedge clk); k++;
            if (wb_valid) found = 1'b1;
        end
        checks++;
        if (!found || wb_addr !== {17'h7, 2'd2})
            $display("FAIL rst_wb_seen: got valid=%0d addr %0h expected 1/%0h", found, wb_addr, {17'h7, 2'd2});
        else passed++;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wb_valid, lock_req, flush_busy} !== 3'b000)
            $display("FAIL rst_immediate: got %b expected 000", {wb_valid, lock_req, flush_busy});
        else passed++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (ws_idx.size() != ws0 || wba_q.size() != wb0)
            $display("FAIL rst_no_activity: got ws=%0d wb=%0d expected 0/0",
                     ws_idx.size() - ws0, wba_q.size() - wb0);
        else passed++;
        set_line(0, 17'h0, '0, LS_E);
        set_line(2, 17'h0, '0, LS_I);
        wb_ready = 1'b1;
        start_flush(1'b1);
        wait_done(40, cyc, found);
        checks++;
        if (!found || cyc != 11 || ws_idx.size() - ws0 != 1)
            $display("FAIL rst_resweep: got found=%0d cyc=%0d ws=%0d expected 1/11/1",
                     found, cyc, ws_idx.size() - ws0);
        else if (ws_idx[ws0] !== 2'd0 || ws_val[ws0] !== LS_I)
            $display("FAIL rst_resweep_line: got idx %0d st %0d expected 0/0", ws_idx[ws0], ws_val[ws0]);
        else passed++;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) set_line(i, 17'h0, '0, LS_I);
        test_reset();
        test_all_invalid();
        test_mixed(1'b1);
        test_mixed(1'b0);
        test_wb_stall();
        test_gnt_delay();
        test_reset_mid_wb();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
